// File: rtl/mem_arbiter.sv
// Arbitrates the single pmem port between the IFU (reads only) and the LSU (reads/writes).
// Round-robin grant in IDLE, fixed MEM_LAT-cycle memory window, one-cycle response pulse.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [DATA_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_valid,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t           state;
    owner_t           owner;
    owner_t           last_grant;
    logic [CNT_W-1:0] cnt;
    logic             wen_q;
    logic             grant_ifu;
    logic             grant_lsu;
    logic [DATA_WIDTH-1:0] grant_addr;

    // LSU wins only if it is alone or the IFU had the previous grant.
    always_comb begin
        grant_lsu  = lsu_req_valid && (!ifu_req_valid || last_grant == OWN_IFU);
        grant_ifu  = ifu_req_valid && !grant_lsu;
        grant_addr = grant_lsu ? lsu_addr : ifu_addr;
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign ifu_req_ready = rst_n && (state == IDLE) && grant_ifu;
    assign lsu_req_ready = rst_n && (state == IDLE) && grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= OWN_IFU;
            last_grant     <= OWN_LSU;
            cnt            <= '0;
            wen_q          <= 1'b0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            mem_valid      <= 1'b0;
            mem_wen        <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= '0;
            mem_raddr      <= '0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
                        last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
                        cnt        <= '0;
                        wen_q      <= grant_lsu && lsu_wen;
                        mem_valid  <= 1'b1;
                        mem_wen    <= grant_lsu && lsu_wen;
                        mem_raddr  <= grant_addr;
                        mem_waddr  <= grant_addr;
                        mem_wdata  <= grant_lsu ? lsu_wdata : '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write strobe lives only in the first window cycle: one pmem write per store.
                    mem_wen <= 1'b0;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        mem_valid <= 1'b0;
                        mem_raddr <= '0;
                        mem_waddr <= '0;
                        mem_wdata <= '0;
                        state     <= RESP;
                        if (owner == OWN_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= wen_q ? '0 : mem_rdata;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance a (MEM_LAT=1) driven from a cycle table,
// instance b (MEM_LAT=3) driven by hand-written multi-cycle sequences.
module tb_mem_arbiter;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A4 = 32'h8000_0004;
    localparam logic [31:0] A8 = 32'h8000_0008;
    localparam logic [31:0] AX = 32'h8000_0010;
    localparam logic [31:0] AS = 32'h8000_1000;
    localparam logic [31:0] W0 = 32'h0000_0413;
    localparam logic [31:0] W4 = 32'h1111_1111;
    localparam logic [31:0] W8 = 32'h2222_2222;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] preset(input logic [31:0] addr);
        case (addr)
            A0:      preset = W0;
            A4:      preset = W4;
            A8:      preset = W8;
            default: preset = ~addr;
        endcase
    endfunction

    // ---------------- instance a, MEM_LAT = 1 ----------------
    logic        a_rst_n = 1'b0;
    logic        a_ifu_v = 1'b0, a_lsu_v = 1'b0, a_lsu_wen = 1'b0;
    logic [31:0] a_ifu_addr = '0, a_lsu_addr = '0, a_lsu_wdata = '0;
    logic        a_ifu_req_ready, a_ifu_resp_valid, a_lsu_req_ready, a_lsu_resp_valid;
    logic        a_mem_valid, a_mem_wen;
    logic [31:0] a_ifu_rdata, a_lsu_rdata, a_mem_waddr, a_mem_wdata, a_mem_raddr, a_mem_rdata;
    logic        a_wr_seen = 1'b0;
    logic [31:0] a_wr_addr = '0, a_wr_data = '0;
    int          a_wr_cnt = 0;

    mem_arbiter #(.DATA_WIDTH(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .ifu_req_valid(a_ifu_v), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(a_ifu_addr),
        .ifu_resp_valid(a_ifu_resp_valid), .ifu_rdata(a_ifu_rdata),
        .lsu_req_valid(a_lsu_v), .lsu_req_ready(a_lsu_req_ready), .lsu_wen(a_lsu_wen),
        .lsu_addr(a_lsu_addr), .lsu_wdata(a_lsu_wdata),
        .lsu_resp_valid(a_lsu_resp_valid), .lsu_rdata(a_lsu_rdata),
        .mem_valid(a_mem_valid), .mem_wen(a_mem_wen), .mem_waddr(a_mem_waddr),
        .mem_wdata(a_mem_wdata), .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata)
    );

    assign a_mem_rdata = (a_wr_seen && a_mem_raddr == a_wr_addr) ? a_wr_data : preset(a_mem_raddr);
    always @(posedge clk) begin
        if (a_mem_valid && a_mem_wen) begin
            a_wr_seen <= 1'b1;
            a_wr_addr <= a_mem_waddr;
            a_wr_data <= a_mem_wdata;
            a_wr_cnt  <= a_wr_cnt + 1;
        end
    end

    logic [165:0] a_out;
    assign a_out = {a_ifu_req_ready, a_lsu_req_ready, a_mem_valid, a_mem_wen, a_mem_raddr,
                    a_mem_waddr, a_mem_wdata, a_ifu_resp_valid, a_ifu_rdata,
                    a_lsu_resp_valid, a_lsu_rdata};

    // ---------------- instance b, MEM_LAT = 3 ----------------
    logic        b_rst_n = 1'b0;
    logic        b_ifu_v = 1'b0, b_lsu_v = 1'b0, b_lsu_wen = 1'b0;
    logic [31:0] b_ifu_addr = '0, b_lsu_addr = '0, b_lsu_wdata = '0;
    logic        b_ifu_req_ready, b_ifu_resp_valid, b_lsu_req_ready, b_lsu_resp_valid;
    logic        b_mem_valid, b_mem_wen;
    logic [31:0] b_ifu_rdata, b_lsu_rdata, b_mem_waddr, b_mem_wdata, b_mem_raddr, b_mem_rdata;
    logic        b_wr_seen = 1'b0;
    logic [31:0] b_wr_addr = '0, b_wr_data = '0;
    int          b_wr_cnt = 0;

    mem_arbiter #(.DATA_WIDTH(32), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .ifu_req_valid(b_ifu_v), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_rdata(b_ifu_rdata),
        .lsu_req_valid(b_lsu_v), .lsu_req_ready(b_lsu_req_ready), .lsu_wen(b_lsu_wen),
        .lsu_addr(b_lsu_addr), .lsu_wdata(b_lsu_wdata),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_rdata(b_lsu_rdata),
        .mem_valid(b_mem_valid), .mem_wen(b_mem_wen), .mem_waddr(b_mem_waddr),
        .mem_wdata(b_mem_wdata), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata)
    );

    assign b_mem_rdata = (b_wr_seen && b_mem_raddr == b_wr_addr) ? b_wr_data : preset(b_mem_raddr);
    always @(posedge clk) begin
        if (b_mem_valid && b_mem_wen) begin
            b_wr_seen <= 1'b1;
            b_wr_addr <= b_mem_waddr;
            b_wr_data <= b_mem_wdata;
            b_wr_cnt  <= b_wr_cnt + 1;
        end
    end

    logic [165:0] b_out;
    assign b_out = {b_ifu_req_ready, b_lsu_req_ready, b_mem_valid, b_mem_wen, b_mem_raddr,
                    b_mem_waddr, b_mem_wdata, b_ifu_resp_valid, b_ifu_rdata,
                    b_lsu_resp_valid, b_lsu_rdata};

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic        lw;
        logic [31:0] la;
        logic [31:0] ld;
        logic [165:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [31:0] ia, input logic lv, input logic lw,
                       input logic [31:0] la, input logic [31:0] ld,
                       input logic ir, input logic lr, input logic mv, input logic mw,
                       input logic [31:0] ma, input logic [31:0] md,
                       input logic irv, input logic [31:0] ird,
                       input logic lrv, input logic [31:0] lrd);
        vec_t v;
        v.iv = iv; v.ia = ia; v.lv = lv; v.lw = lw; v.la = la; v.ld = ld;
        v.exp = {ir, lr, mv, mw, ma, ma, md, irv, ird, lrv, lrd};
        vq.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mv_cnt;
        int resp_at;
        int ifu_resp_cnt;
        logic wen_seen;
        logic lresp_seen;
        logic [31:0] rd;
        int c0;

        //   iv ia  lv lw la  ld        | ir lr mv mw ma  md  irv ird lrv lrd
        // both requesters valid from reset: IFU, LSU, IFU, LSU
        add(1, A4, 1, 0, A8, 0,          1, 0, 0, 0, 0,  0,  0, 0,  0, 0);
        add(1, A4, 1, 0, A8, 0,          0, 0, 1, 0, A4, 0,  0, 0,  0, 0);
        add(1, A4, 1, 0, A8, 0,          0, 0, 0, 0, 0,  0,  1, W4, 0, 0);
        add(1, A4, 1, 0, A8, 0,          0, 1, 0, 0, 0,  0,  0, W4, 0, 0);
        add(1, A4, 1, 0, A8, 0,          0, 0, 1, 0, A8, 0,  0, W4, 0, 0);
        add(1, A4, 1, 0, A8, 0,          0, 0, 0, 0, 0,  0,  0, W4, 1, W8);
        add(1, A4, 1, 0, A8, 0,          1, 0, 0, 0, 0,  0,  0, W4, 0, W8);
        add(1, A4, 1, 0, A8, 0,          0, 0, 1, 0, A4, 0,  0, W4, 0, W8);
        add(1, A4, 1, 0, A8, 0,          0, 0, 0, 0, 0,  0,  1, W4, 0, W8);
        add(1, A4, 1, 0, A8, 0,          0, 1, 0, 0, 0,  0,  0, W4, 0, W8);
        add(0, A4, 0, 0, A8, 0,          0, 0, 1, 0, A8, 0,  0, W4, 0, W8);
        add(0, A4, 0, 0, A8, 0,          0, 0, 0, 0, 0,  0,  0, W4, 1, W8);
        // IFU alone: ready at T, mem_valid at T+1, response at T+2
        add(1, A0, 0, 0, 0,  0,          1, 0, 0, 0, 0,  0,  0, W4, 0, W8);
        add(0, A0, 0, 0, 0,  0,          0, 0, 1, 0, A0, 0,  0, W4, 0, W8);
        add(0, A0, 0, 0, 0,  0,          0, 0, 0, 0, 0,  0,  1, W0, 0, W8);
        add(0, A0, 0, 0, 0,  0,          0, 0, 0, 0, 0,  0,  0, W0, 0, W8);
        // store then load of the same word; wdata changed after accept is ignored
        add(0, 0,  1, 1, AS, DB,         0, 1, 0, 0, 0,  0,  0, W0, 0, W8);
        add(0, 0,  0, 1, AS, 32'h12345678, 0, 0, 1, 1, AS, DB, 0, W0, 0, W8);
        add(0, 0,  0, 0, AS, 0,          0, 0, 0, 0, 0,  0,  0, W0, 1, 0);
        add(0, 0,  1, 0, AS, 0,          0, 1, 0, 0, 0,  0,  0, W0, 0, 0);
        add(0, 0,  0, 0, AS, 0,          0, 0, 1, 0, AS, 0,  0, W0, 0, 0);
        add(0, 0,  0, 0, AS, 0,          0, 0, 0, 0, 0,  0,  0, W0, 1, DB);
        // IFU address wanders while the LSU is in flight; the accept-cycle one is used
        add(0, 0,  1, 0, A8, 0,          0, 1, 0, 0, 0,  0,  0, W0, 0, DB);
        add(1, AX, 0, 0, A8, 0,          0, 0, 1, 0, A8, 0,  0, W0, 0, DB);
        add(1, A4, 0, 0, A8, 0,          0, 0, 0, 0, 0,  0,  0, W0, 1, W8);
        add(1, A0, 0, 0, A8, 0,          1, 0, 0, 0, 0,  0,  0, W0, 0, W8);
        add(0, AX, 0, 0, A8, 0,          0, 0, 1, 0, A0, 0,  0, W0, 0, W8);
        add(0, AX, 0, 0, A8, 0,          0, 0, 0, 0, 0,  0,  1, W0, 0, W8);

        // reset state, with requests present to show ready stays low
        a_ifu_v = 1'b1; a_lsu_v = 1'b1;
        b_ifu_v = 1'b1; b_lsu_v = 1'b1;
        @(negedge clk);
        chk("a_reset", a_out, '0);
        chk("b_reset", b_out, '0);
        @(posedge clk); #1;
        a_ifu_v = 1'b0; a_lsu_v = 1'b0;
        b_ifu_v = 1'b0; b_lsu_v = 1'b0;
        a_rst_n = 1'b1;

        foreach (vq[i]) begin
            @(posedge clk); #1;
            a_ifu_v = vq[i].iv; a_ifu_addr = vq[i].ia;
            a_lsu_v = vq[i].lv; a_lsu_wen = vq[i].lw;
            a_lsu_addr = vq[i].la; a_lsu_wdata = vq[i].ld;
            @(negedge clk);
            chk($sformatf("a_vec%0d", i), a_out, vq[i].exp);
        end
        chk("a_write_count", a_wr_cnt, 1);

        // b: MEM_LAT=3 load, mem_valid exactly 3 cycles, response at T+4
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        b_lsu_v = 1'b1; b_lsu_wen = 1'b0; b_lsu_addr = A4;
        @(negedge clk);
        chk("b_load_ready", b_lsu_req_ready, 1);
        mv_cnt = 0; resp_at = 0; wen_seen = 1'b0; rd = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            b_lsu_v = 1'b0;
            @(negedge clk);
            if (b_mem_valid) mv_cnt++;
            if (b_mem_wen) wen_seen = 1'b1;
            if (b_lsu_resp_valid && resp_at == 0) begin
                resp_at = k;
                rd = b_lsu_rdata;
            end
        end
        chk("b_load_valid_cycles", mv_cnt, 3);
        chk("b_load_wen", wen_seen, 0);
        chk("b_load_resp_cycle", resp_at, 4);
        chk("b_load_rdata", rd, W4);

        // b: store, reset in its second ACCESS cycle
        c0 = b_wr_cnt;
        @(posedge clk); #1;
        b_lsu_v = 1'b1; b_lsu_wen = 1'b1; b_lsu_addr = AS; b_lsu_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("b_store_ready", b_lsu_req_ready, 1);
        @(posedge clk); #1;
        b_lsu_v = 1'b1; b_lsu_wen = 1'b0; b_lsu_addr = A8;
        b_ifu_v = 1'b1; b_ifu_addr = A0;
        @(negedge clk);
        chk("b_store_first_access", {b_mem_valid, b_mem_wen}, 2'b11);
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        #1;
        chk("b_reset_mid_access", b_out, '0);
        lresp_seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (b_lsu_resp_valid) lresp_seen = 1'b1;
        end
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        @(negedge clk);
        chk("b_tie_after_reset", {b_ifu_req_ready, b_lsu_req_ready}, 2'b10);
        chk("b_store_write_count", b_wr_cnt - c0, 1);
        @(posedge clk); #1;
        b_lsu_v = 1'b0; b_ifu_v = 1'b0;
        ifu_resp_cnt = 0; rd = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b_lsu_resp_valid) lresp_seen = 1'b1;
            if (b_ifu_resp_valid) begin
                ifu_resp_cnt++;
                rd = b_ifu_rdata;
            end
        end
        chk("b_no_dropped_store_resp", lresp_seen, 0);
        chk("b_ifu_resp_count", ifu_resp_cnt, 1);
        chk("b_ifu_rdata", rd, W0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
